// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl: manual-mode front end for the 16-LED display.
// Synchronises and debounces btnL/btnR, turns accepted presses into one-cycle
// step events and moves a one-hot LED position with saturation at 0 and 15.
// Define BTN_AUTOREPEAT_EN to compile in the shared auto-repeat FSM; without
// it a held button steps exactly once.
module btn_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        btnL,
    input  logic        btnR,
    output logic [15:0] LED,
    output logic [3:0]  idx,
    output logic        evt_l,
    output logic        evt_r
);

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Marker block that appears in the elaborated hierarchy when a timing
    // parameter is below one cycle, which no counter here can honour.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_invalid_timing_params
    end

    // Bit 0 of every per-button vector is the left button, bit 1 the right.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d, stable_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      press, accept, rep, step;
    logic [3:0]      idx_q, idx_d;
    logic [15:0]     led_q;
    logic            evt_l_q, evt_r_q;

    assign btn_raw = {btnR, btnL};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking so sync2_q takes the previous sync1_q; blocking
            // assignments here would collapse the two stages into one.
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: count while the input disagrees with the stable level.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            // NOTE: every output gets a default first, so no path leaves a
            // value unassigned and no latch is inferred.
            stable_d[b] = stable_q[b];
            db_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = ~stable_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Debounce state plus a delayed copy of the stable level for edge detection.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            db_cnt_q[0]   <= '0;
            db_cnt_q[1]   <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q[0]   <= db_cnt_d[0];
            db_cnt_q[1]   <= db_cnt_d[1];
        end
    end

    // A press is the cycle after the stable level rises; it only counts while
    // the other button is released, so simultaneous presses cancel each other.
    assign press  = stable_q & ~stable_prev_q;
    assign accept = {press[1] & ~stable_q[0], press[0] & ~stable_q[1]};

`ifdef BTN_AUTOREPEAT_EN
    localparam int RD_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int RR_W = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam int RC_W = (RD_W > RR_W) ? RD_W : RR_W;
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RR_LAST = RC_W'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [RC_W-1:0] rep_cnt_q, rep_cnt_d;
    logic            held_q, held_d;     // 0 = left held, 1 = right held
    logic            held_on, other_on;

    assign held_on  = stable_q[held_q];
    assign other_on = stable_q[~held_q];

    // Repeat FSM: arm on an accepted press, drop out as soon as the held button
    // is released or the other one goes down, otherwise emit timed repeats.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        held_d    = held_q;
        rep       = '0;
        if (|accept) begin
            state_d   = ST_DELAY;
            rep_cnt_d = '0;
            held_d    = accept[1];
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DELAY, ST_REPEAT: begin
                    if (!held_on || other_on) begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == ((state_q == ST_DELAY) ? RD_LAST : RR_LAST)) begin
                        rep[held_q] = 1'b1;
                        state_d     = ST_REPEAT;
                        rep_cnt_d   = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    // Repeat FSM registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            held_q    <= held_d;
        end
    end
`else
    assign rep = 2'b00;
`endif

    assign step = accept | rep;

    // Saturating position update; left moves up, right moves down.
    always_comb begin
        idx_d = idx_q;
        if (step[0]) begin
            if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
        end else if (step[1]) begin
            if (idx_q != 4'd0) idx_d = idx_q - 4'd1;
        end
    end

    // Registered outputs; position and LED share one next-state value.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            idx_q   <= 4'd0;
            led_q   <= 16'h0001;
            evt_l_q <= 1'b0;
            evt_r_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            led_q   <= 16'h0001 << idx_d;
            evt_l_q <= step[0];
            evt_r_q <= step[1];
        end
    end

    assign idx   = idx_q;
    assign LED   = led_q;
    assign evt_l = evt_l_q;
    assign evt_r = evt_r_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// tb_btn_led_ctrl: directed and randomized stimulus for btn_led_ctrl, checked
// every cycle against a behavioural model built from the button rules.
module tb_btn_led_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        btn_l, btn_r;
    logic [15:0] led;
    logic [3:0]  idx;
    logic        evt_l, evt_r;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: raw sample history, stable levels, repeat schedule.
    logic [63:0] hist_l, hist_r;
    bit          st_l, st_r, st_l_prev, st_r_prev;
    int          m_idx;
    bit          m_evt_l, m_evt_r;
    bit          rep_on, rep_right;
    int          rep_start;
    int          cyc = 0;
    int          dut_evt_l_cnt, dut_evt_r_cnt;

    btn_led_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .btnL      (btn_l),
        .btnR      (btn_r),
        .LED       (led),
        .idx       (idx),
        .evt_l     (evt_l),
        .evt_r     (evt_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist_l    = '0;
        hist_r    = '0;
        st_l      = 1'b0;
        st_r      = 1'b0;
        st_l_prev = 1'b0;
        st_r_prev = 1'b0;
        m_idx     = 0;
        m_evt_l   = 1'b0;
        m_evt_r   = 1'b0;
        rep_on    = 1'b0;
        rep_right = 1'b0;
        rep_start = 0;
    endtask

    // One clock edge of the model. A level is accepted once the last DB
    // synchronised samples (raw delayed two edges) all disagree with it.
    task automatic model_step(input logic rl, input logic rr);
        bit          acc_l, acc_r, rep_l, rep_r, held_st, other_st;
        logic [63:0] mask, win;
        int          age;
        acc_l = st_l && !st_l_prev && !st_r;
        acc_r = st_r && !st_r_prev && !st_l;
        rep_l = 1'b0;
        rep_r = 1'b0;
        if (AUTOREP) begin
            if (acc_l || acc_r) begin
                rep_on    = 1'b1;
                rep_right = acc_r;
                rep_start = cyc;
            end else if (rep_on) begin
                held_st  = rep_right ? st_r : st_l;
                other_st = rep_right ? st_l : st_r;
                age      = cyc - rep_start;
                if (!held_st || other_st) rep_on = 1'b0;
                else if (age >= RD && (age - RD) % RR == 0) begin
                    if (rep_right) rep_r = 1'b1;
                    else rep_l = 1'b1;
                end
            end
        end
        m_evt_l = acc_l || rep_l;
        m_evt_r = acc_r || rep_r;
        if (m_evt_l) m_idx = (m_idx < 15) ? m_idx + 1 : 15;
        if (m_evt_r) m_idx = (m_idx > 0) ? m_idx - 1 : 0;
        st_l_prev = st_l;
        st_r_prev = st_r;
        hist_l = {hist_l[62:0], rl};
        hist_r = {hist_r[62:0], rr};
        mask = (64'd1 << DB) - 64'd1;
        win = (hist_l >> 2) & mask;
        if (st_l ? (win == 64'd0) : (win == mask)) st_l = !st_l;
        win = (hist_r >> 2) & mask;
        if (st_r ? (win == 64'd0) : (win == mask)) st_r = !st_r;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(btn_l, btn_r);
        #1;
        if (evt_l === 1'b1) dut_evt_l_cnt++;
        if (evt_r === 1'b1) dut_evt_r_cnt++;
        check("evt_l", 16'(evt_l), 16'(m_evt_l));
        check("evt_r", 16'(evt_r), 16'(m_evt_r));
        check("idx", 16'(idx), 16'(m_idx));
        check("led", led, 16'h0001 << m_idx);
    endtask

    task automatic hold(input logic bl, input logic br, input int n);
        btn_l = bl;
        btn_r = br;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        btn_l = 1'b0;
        btn_r = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic press_l();
        hold(1'b1, 1'b0, 8);
        hold(1'b0, 1'b0, 8);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
        model_reset();
        dut_evt_l_cnt = 0;
        dut_evt_r_cnt = 0;

        // Reset state, no stimulus.
        repeat (3) tick();
        rst_n = 1'b1;
        hold(1'b0, 1'b0, 5);
        check("rst_led", led, 16'h0001);
        check("rst_idx", 16'(idx), 16'd0);
        check("rst_evt_cnt", 16'(dut_evt_l_cnt + dut_evt_r_cnt), 16'd0);

        // Single 10-cycle press, then a 3-cycle glitch.
        dut_evt_l_cnt = 0;
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 12);
        check("press_evt_cnt", 16'(dut_evt_l_cnt), 16'd1);
        check("press_idx", 16'(idx), 16'd1);
        check("press_led", led, 16'h0002);
        dut_evt_l_cnt = 0;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 10);
        check("glitch_evt_cnt", 16'(dut_evt_l_cnt), 16'd0);
        check("glitch_idx", 16'(idx), 16'd1);

        // Five presses, then asynchronous reset between clock edges.
        do_reset();
        repeat (5) press_l();
        check("five_idx", 16'(idx), 16'd5);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_idx", 16'(idx), 16'd0);
        check("async_rst_led", led, 16'h0001);
        check("async_rst_evt", {14'd0, evt_r, evt_l}, 16'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Sixteen presses saturate at 15; the last one still pulses.
        for (int i = 0; i < 16; i++) begin
            dut_evt_l_cnt = 0;
            press_l();
        end
        check("sat_hi_idx", 16'(idx), 16'd15);
        check("sat_hi_led", led, 16'h8000);
        check("sat_hi_last_evt", 16'(dut_evt_l_cnt), 16'd1);

        // Right press at 0 pulses but stays at 0.
        do_reset();
        dut_evt_r_cnt = 0;
        hold(1'b0, 1'b1, 8);
        hold(1'b0, 1'b0, 8);
        check("sat_lo_evt", 16'(dut_evt_r_cnt), 16'd1);
        check("sat_lo_idx", 16'(idx), 16'd0);

        // Both buttons together: nothing accepted.
        press_l();
        press_l();
        dut_evt_l_cnt = 0;
        dut_evt_r_cnt = 0;
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b0, 8);
        check("both_evt", 16'(dut_evt_l_cnt + dut_evt_r_cnt), 16'd0);
        check("both_idx", 16'(idx), 16'd2);

        // Hold right, press left meanwhile: left ignored and repeat cancelled.
        hold(1'b0, 1'b1, 8);
        check("held_r_idx", 16'(idx), 16'd1);
        dut_evt_l_cnt = 0;
        dut_evt_r_cnt = 0;
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b1, 30);
        hold(1'b0, 1'b0, 10);
        check("blocked_l_evt", 16'(dut_evt_l_cnt), 16'd0);
        check("cancel_r_evt", 16'(dut_evt_r_cnt), 16'd0);
        check("blocked_idx", 16'(idx), 16'd1);

        // 50-cycle hold after the press event.
        do_reset();
        dut_evt_l_cnt = 0;
        btn_l = 1'b1;
        for (int i = 0; i < 20 && !m_evt_l; i++) tick();
        check("hold_press", 16'(evt_l), 16'd1);
        hold(1'b1, 1'b0, 50);
        check("hold_evt_cnt", 16'(dut_evt_l_cnt), AUTOREP ? 16'd8 : 16'd1);
        check("hold_idx", 16'(idx), AUTOREP ? 16'd8 : 16'd1);
        hold(1'b0, 1'b0, 15);

        // Randomized button activity against the model.
        for (int i = 0; i < 40; i++) begin
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 40));
        end
        hold(1'b0, 1'b0, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
